// File: rtl/input_port_conditioner.sv
// Front-panel input conditioner: synchronises the switch bank and push-button, debounces the button,
// latches the switches on each accepted press, and drives in_port/ready_in. Optional macro: AUTO_REPEAT_EN.
module input_port_conditioner #(
   parameter int BUS_WIDTH       = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 1024
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic [BUS_WIDTH-1:0] sw_raw,
   input  logic                 btn_raw,
   output logic [BUS_WIDTH-1:0] in_port,
   output logic                 ready_in
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DONE = DW'(1);

`ifdef AUTO_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
   localparam logic [RW-1:0] RONE = RW'(1);
`endif

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      ARM_PRESS   = 3'd1,
      CAPTURE     = 3'd2,
      PRESSED     = 3'd3,
      ARM_RELEASE = 3'd4
`ifdef AUTO_REPEAT_EN
      ,
      REPEAT_GAP  = 3'd5
`endif
   } state_t;

   state_t                state_q, state_d;
   logic                  btn_meta_q, btn_meta_d;
   logic                  btn_s_q, btn_s_d;
   logic [BUS_WIDTH-1:0]  sw_meta_q, sw_meta_d;
   logic [BUS_WIDTH-1:0]  sw_s_q, sw_s_d;
   logic [DW-1:0]         dcnt_q, dcnt_d;
   logic [BUS_WIDTH-1:0]  in_port_q, in_port_d;
   logic                  ready_in_q, ready_in_d;
`ifdef AUTO_REPEAT_EN
   logic [RW-1:0]         rcnt_q, rcnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      dcnt_d     = dcnt_q;
      in_port_d  = in_port_q;
      ready_in_d = ready_in_q;
      btn_meta_d = btn_raw;
      btn_s_d    = btn_meta_q;
      sw_meta_d  = sw_raw;
      sw_s_d     = sw_meta_q;
`ifdef AUTO_REPEAT_EN
      rcnt_d     = rcnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (btn_s_q) begin
               state_d = ARM_PRESS;
               dcnt_d  = DONE;
            end else begin
               dcnt_d  = '0;
            end
         end

         ARM_PRESS: begin
            if (!btn_s_q) begin
               state_d = IDLE;
               dcnt_d  = '0;
            end else if (dcnt_q == DMAX) begin
               state_d   = CAPTURE;
               in_port_d = sw_s_q;
            end else begin
               dcnt_d = dcnt_q + DONE;
            end
         end

         // in_port settled on the previous edge; raise ready_in one cycle later
         CAPTURE: begin
            state_d    = PRESSED;
            ready_in_d = 1'b1;
            dcnt_d     = '0;
`ifdef AUTO_REPEAT_EN
            rcnt_d     = '0;
`endif
         end

         PRESSED: begin
`ifdef AUTO_REPEAT_EN
            if (btn_s_q && rcnt_q == RMAX) begin
               state_d    = REPEAT_GAP;
               ready_in_d = 1'b0;
               in_port_d  = sw_s_q;
               rcnt_d     = '0;
            end else begin
               if (rcnt_q != RMAX) begin
                  rcnt_d = rcnt_q + RONE;
               end
               if (!btn_s_q) begin
                  state_d = ARM_RELEASE;
                  dcnt_d  = DONE;
               end
            end
`else
            if (!btn_s_q) begin
               state_d = ARM_RELEASE;
               dcnt_d  = DONE;
            end
`endif
         end

         // rcnt is deliberately left alone here so a release bounce does not restart the repeat period
         ARM_RELEASE: begin
            if (btn_s_q) begin
               state_d = PRESSED;
               dcnt_d  = '0;
            end else if (dcnt_q == DMAX) begin
               state_d    = IDLE;
               ready_in_d = 1'b0;
`ifdef AUTO_REPEAT_EN
               rcnt_d     = '0;
`endif
            end else begin
               dcnt_d = dcnt_q + DONE;
            end
         end

`ifdef AUTO_REPEAT_EN
         REPEAT_GAP: begin
            state_d    = PRESSED;
            ready_in_d = 1'b1;
         end
`endif

         default: begin
            state_d = IDLE;
            dcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q    <= IDLE;
         btn_meta_q <= 1'b0;
         btn_s_q    <= 1'b0;
         sw_meta_q  <= '0;
         sw_s_q     <= '0;
         dcnt_q     <= '0;
         in_port_q  <= '0;
         ready_in_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         btn_meta_q <= btn_meta_d;
         btn_s_q    <= btn_s_d;
         sw_meta_q  <= sw_meta_d;
         sw_s_q     <= sw_s_d;
         dcnt_q     <= dcnt_d;
         in_port_q  <= in_port_d;
         ready_in_q <= ready_in_d;
`ifdef AUTO_REPEAT_EN
         rcnt_q     <= rcnt_d;
`endif
      end
   end

   assign in_port  = in_port_q;
   assign ready_in = ready_in_q;

endmodule

// File: tb/tb_input_port_conditioner.sv
// Scoreboard bench for input_port_conditioner (D=4, REPEAT_CYCLES=8): stimulus queues expected
// output-change events with their cycle numbers; a monitor pops and compares on every output change.
module tb_input_port_conditioner;

   localparam int BW = 8;
   localparam int D  = 4;
   localparam int RC = 8;

   logic          clk = 1'b0;
   logic          n_reset;
   logic [BW-1:0] sw_raw;
   logic          btn_raw;
   logic [BW-1:0] in_port;
   logic          ready_in;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int rise_cnt = 0;
   logic mon_en = 1'b0;

   typedef struct {
      int            c;
      logic          rdy;
      logic [BW-1:0] val;
   } ev_t;

   ev_t exp_q[$];

   input_port_conditioner #(
      .BUS_WIDTH      (BW),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_CYCLES  (RC)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .sw_raw  (sw_raw),
      .btn_raw (btn_raw),
      .in_port (in_port),
      .ready_in(ready_in)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int c, input logic r, input logic [BW-1:0] v);
      ev_t e;
      e.c   = c;
      e.rdy = r;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", nm, got, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor: every change of {ready_in, in_port} is one transaction
   initial begin : monitor
      logic [BW:0] cur;
      logic [BW:0] prev;
      ev_t e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {ready_in, in_port};
         if (mon_en && cur !== prev) begin
            if (ready_in === 1'b1 && prev[BW] === 1'b0) rise_cnt++;
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change: got cycle %0d ready=%b in_port=%h, want no change",
                        cyc, ready_in, in_port);
            end else begin
               e = exp_q.pop_front();
               if (e.c != cyc || e.rdy !== ready_in || e.val !== in_port) begin
                  n_fail++;
                  $display("FAIL event: got cycle %0d ready=%b in_port=%h, want cycle %0d ready=%b in_port=%h",
                           cyc, ready_in, in_port, e.c, e.rdy, e.val);
               end else begin
                  $display("ok   event: cycle %0d ready=%b in_port=%h", cyc, ready_in, in_port);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout, want test end");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int c;
      int r0;
      n_reset = 1'b0;
      btn_raw = 1'b0;
      sw_raw  = '0;
      step(3);
      chk("reset_ready_in", {7'd0, ready_in}, 8'h00);
      chk("reset_in_port", in_port, 8'h00);
      n_reset = 1'b1;
      mon_en  = 1'b1;
      step(4);

      // clean press and release
      c = cyc; sw_raw = 8'hA5; btn_raw = 1'b1;
      expect_ev(c + D + 2, 1'b0, 8'hA5);
      expect_ev(c + D + 3, 1'b1, 8'hA5);
      step(11);
      c = cyc; btn_raw = 1'b0;
      expect_ev(c + D + 2, 1'b0, 8'hA5);
      step(10);
      chk("release_keeps_in_port", in_port, 8'hA5);

      // bounce rejected: high 2, low 3, high 1, low; switches move meanwhile
      btn_raw = 1'b1; sw_raw = 8'h11; step(2);
      btn_raw = 1'b0; step(3);
      btn_raw = 1'b1; step(1);
      btn_raw = 1'b0; step(10);
      chk("bounce_ready_in", {7'd0, ready_in}, 8'h00);
      chk("bounce_in_port", in_port, 8'hA5);

      // release bounce: two low cycles while pressed must not drop ready_in
      c = cyc; sw_raw = 8'h5A; btn_raw = 1'b1;
      expect_ev(c + D + 2, 1'b0, 8'h5A);
      expect_ev(c + D + 3, 1'b1, 8'h5A);
      step(9);
      btn_raw = 1'b0; step(2);
      btn_raw = 1'b1; step(2);
      c = cyc; btn_raw = 1'b0;
      expect_ev(c + D + 2, 1'b0, 8'h5A);
      step(10);

      // switch change during a press is ignored until the next press
      c = cyc; sw_raw = 8'h3C; btn_raw = 1'b1;
      expect_ev(c + D + 2, 1'b0, 8'h3C);
      expect_ev(c + D + 3, 1'b1, 8'h3C);
      step(6);
      sw_raw = 8'hFF; step(5);
      c = cyc; btn_raw = 1'b0;
      expect_ev(c + D + 2, 1'b0, 8'h3C);
      step(10);
      c = cyc; btn_raw = 1'b1;
      expect_ev(c + D + 2, 1'b0, 8'hFF);
      expect_ev(c + D + 3, 1'b1, 8'hFF);
      step(11);
      c = cyc; btn_raw = 1'b0;
      expect_ev(c + D + 2, 1'b0, 8'hFF);
      step(10);

      // reset mid-press with the button still held
      c = cyc; sw_raw = 8'h77; btn_raw = 1'b1;
      expect_ev(c + D + 2, 1'b0, 8'h77);
      expect_ev(c + D + 3, 1'b1, 8'h77);
      step(10);
      c = cyc; n_reset = 1'b0;
      expect_ev(c + 1, 1'b0, 8'h00);
      step(1);
      n_reset = 1'b1;
      expect_ev(c + D + 3, 1'b0, 8'h77);
      expect_ev(c + D + 4, 1'b1, 8'h77);
      step(10);
      c = cyc; btn_raw = 1'b0;
      expect_ev(c + D + 2, 1'b0, 8'h77);
      step(10);

      // long hold: auto-repeat when enabled, a single rising edge otherwise
      r0 = rise_cnt;
      c = cyc; sw_raw = 8'h42; btn_raw = 1'b1;
      expect_ev(c + D + 2, 1'b0, 8'h42);
      expect_ev(c + D + 3, 1'b1, 8'h42);
`ifdef AUTO_REPEAT_EN
      expect_ev(c + D + 3 + RC,         1'b0, 8'h42);
      expect_ev(c + D + 4 + RC,         1'b1, 8'h42);
      expect_ev(c + D + 4 + 2 * RC,     1'b0, 8'h99);
      expect_ev(c + D + 5 + 2 * RC,     1'b1, 8'h99);
      expect_ev(c + 36,                 1'b0, 8'h99);
`else
      expect_ev(c + 36,                 1'b0, 8'h42);
`endif
      step(18);
      sw_raw = 8'h99; step(12);
      btn_raw = 1'b0; step(12);
`ifdef AUTO_REPEAT_EN
      chk("hold_rising_edges", 8'(rise_cnt - r0), 8'd3);
      chk("hold_final_in_port", in_port, 8'h99);
`else
      chk("hold_rising_edges", 8'(rise_cnt - r0), 8'd1);
      chk("hold_final_in_port", in_port, 8'h42);
`endif

      step(5);
      chk("scoreboard_leftover", 8'(exp_q.size()), 8'd0);
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         $display("FAIL missing_event: got none, want cycle %0d ready=%b in_port=%h", e.c, e.rdy, e.val);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
